// File: rtl/hazard_forward_ctrl.sv
// Stateful hazard/forwarding controller: shadows EX and MEM destinations, raises load-use stalls
// and registers operand-forward selects for the EX stage. Optional stall counter: HAZ_STATS_EN.
module hazard_forward_ctrl #(
    parameter int unsigned REG_W    = 32'd5,
    parameter int unsigned NUM_SRC  = 32'd2,
    parameter int unsigned LOAD_LAT = 32'd1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic                       flush,
    input  logic                       dec_valid,
    input  logic [REG_W-1:0]           dec_rd,
    input  logic                       dec_regwrite,
    input  logic                       dec_memread,
    input  logic [NUM_SRC*REG_W-1:0]   dec_rs,
    output logic                       stall,
    output logic [2*NUM_SRC-1:0]       fwd_sel,
    output logic                       ex_valid
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    localparam logic LL2 = (LOAD_LAT == 32'd2);

    logic               ex_v_q, ex_rw_q, ex_ld_q;
    logic [REG_W-1:0]   ex_rd_q;
    logic               mem_v_q, mem_rw_q, mem_ld_q;
    logic [REG_W-1:0]   mem_rd_q;
    logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;
    logic [NUM_SRC-1:0] ex_hit_s, mem_hit_s, src_stall_s;
    logic               accept_s;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [REG_W-1:0] rs_s;
        logic [1:0]       sel_s;

        assign rs_s = dec_rs[g*REG_W +: REG_W];
        assign ex_hit_s[g]  = ex_v_q && ex_rw_q && (ex_rd_q == rs_s) && (rs_s != {REG_W{1'b0}});
        assign mem_hit_s[g] = mem_v_q && mem_rw_q && (mem_rd_q == rs_s) && (rs_s != {REG_W{1'b0}});
        // With a two-cycle load a producer in MEM is not yet available; it is read from the RF later
        assign src_stall_s[g] = (ex_hit_s[g] && ex_ld_q) || (LL2 && mem_hit_s[g] && mem_ld_q);

        // Forward select for this source; the youngest producer wins
        always_comb begin
            sel_s = 2'b00;
            if (ex_hit_s[g]) begin
                sel_s = 2'b01;
            end else if (mem_hit_s[g] && (!LL2 || !mem_ld_q)) begin
                sel_s = 2'b10;
            end else begin
                sel_s = 2'b00;
            end
        end

        assign fwd_sel_d[2*g +: 2] = sel_s;
    end

    assign stall    = dec_valid && (|src_stall_s);
    assign accept_s = dec_valid && !stall && !flush;

    // Shadow pipeline slots and registered forward selects; hold freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q    <= 1'b0;
            ex_rw_q   <= 1'b0;
            ex_ld_q   <= 1'b0;
            ex_rd_q   <= {REG_W{1'b0}};
            mem_v_q   <= 1'b0;
            mem_rw_q  <= 1'b0;
            mem_ld_q  <= 1'b0;
            mem_rd_q  <= {REG_W{1'b0}};
            fwd_sel_q <= {2*NUM_SRC{1'b0}};
        end else if (!hold) begin
            mem_v_q  <= ex_v_q;
            mem_rw_q <= ex_rw_q;
            mem_ld_q <= ex_ld_q;
            mem_rd_q <= ex_rd_q;
            if (accept_s) begin
                ex_v_q    <= 1'b1;
                ex_rw_q   <= dec_regwrite;
                ex_ld_q   <= dec_memread;
                ex_rd_q   <= dec_rd;
                fwd_sel_q <= fwd_sel_d;
            end else begin
                ex_v_q    <= 1'b0;
                ex_rw_q   <= 1'b0;
                ex_ld_q   <= 1'b0;
                ex_rd_q   <= {REG_W{1'b0}};
                fwd_sel_q <= {2*NUM_SRC{1'b0}};
            end
        end
    end

    assign fwd_sel  = fwd_sel_q;
    assign ex_valid = ex_v_q;

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles actually lost to stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else if (!hold && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
